// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store front-end over a word-organised data memory.
// Misaligned-access trapping is optional and enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    input  logic        req_regwrite,
    output logic        stall,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state_r, state_nx_s;
    logic [15:0] addr_r;
    logic [31:0] merged_r;
    logic [4:0]  rd_r;

    logic [15:0] word_addr_s;
    logic [1:0]  boff_s;
    logic        misal_s;
    logic        is_load_s;
    logic        is_wstore_s;
    logic        is_sstore_s;
    logic        unused_s;

    assign unused_s = ^req_addr[31:18];

    // Select the addressed lane and sign/zero-extend it; size 11 behaves as word.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] boff, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (boff)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = boff[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the target lane of the old word with the right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] boff);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: begin
                case (boff)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r[7:0]   = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (boff[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] boff);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = boff[0];
            default: m = (boff != 2'b00);
        endcase
        return m;
    endfunction
`endif

    // Request decode into mutually exclusive access classes.
    always_comb begin
        word_addr_s = req_addr[17:2];
        boff_s      = req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
        misal_s     = req_valid & is_misaligned(req_size, boff_s);
`else
        misal_s     = 1'b0;
`endif
        is_load_s   = req_valid & ~misal_s & ~req_we;
        is_wstore_s = req_valid & ~misal_s & req_we & req_size[1];
        is_sstore_s = req_valid & ~misal_s & req_we & ~req_size[1];
    end

    // Next state and memory-side outputs; only state, req_* and latched registers feed these.
    always_comb begin
        state_nx_s = state_r;
        stall      = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = word_addr_s;
        mem_wdata  = req_wdata;
        case (state_r)
            IDLE: begin
                if (is_sstore_s) begin
                    stall      = 1'b1;
                    state_nx_s = RMW_WR;
                end else if (is_wstore_s) begin
                    mem_write  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RMW_WR: begin
                mem_addr   = addr_r;
                mem_wdata  = merged_r;
                mem_write  = 1'b1;
                state_nx_s = IDLE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, RMW latches and the registered MEM/WB outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            addr_r       <= 16'd0;
            merged_r     <= 32'd0;
            rd_r         <= 5'd0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            misalign_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (misal_s) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= req_rd;
                        misalign_err <= 1'b1;
                    end else if (is_load_s) begin
                        wb_valid    <= 1'b1;
                        wb_regwrite <= req_regwrite;
                        wb_rd       <= req_rd;
                        wb_data     <= load_extend(mem_rdata, req_size, boff_s, req_unsigned);
                    end else if (is_wstore_s) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= req_rd;
                    end else if (is_sstore_s) begin
                        addr_r   <= word_addr_s;
                        merged_r <= store_merge(mem_rdata, req_wdata, req_size, boff_s);
                        rd_r     <= req_rd;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                RMW_WR: begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_r;
                end
                default: wb_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// compared against a byte-addressed memory model.
module tb_mem_access_unit;

    logic        clk, rst;
    logic        req_valid, req_we, req_unsigned, req_regwrite;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        wb_valid, wb_regwrite, misalign_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] dmem [0:65535];
    logic [7:0]  ref_mem [0:255];

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .req_regwrite(req_regwrite),
        .stall(stall), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        int n;
        n = ref_bytes(size);
        return (addr % n) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        int n, base;
        logic [31:0] v, mask;
        n = ref_bytes(size);
        base = int'(addr[7:0]) - (int'(addr[7:0]) % n);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
        if (n < 4 && !uns) begin
            mask = (32'd1 << (8*n)) - 32'd1;
            if (v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n, base;
        n = ref_bytes(size);
        base = int'(addr[7:0]) - (int'(addr[7:0]) % n);
        for (int i = 0; i < n; i++) ref_mem[base+i] = 8'(wdata >> (8*i));
    endtask

    // Present one request at a negedge, hold it through any stall, check its completion.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic regw);
        logic mis, sub;
        logic [31:0] exp_data;
        mis = ref_misaligned(size, addr);
        sub = we && !mis && (ref_bytes(size) < 4);
        exp_data = (!we && !mis) ? ref_load(addr, size, uns) : 32'd0;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = rd; req_regwrite = regw;
        #1;
        check_eq("stall_first", {31'd0, stall}, {31'd0, sub});
        check_eq("memwr_first", {31'd0, mem_write}, {31'd0, we && !mis && !sub});
        check_eq("memaddr_first", {16'd0, mem_addr}, {16'd0, addr[17:2]});
        if (sub) begin
            @(negedge clk); #1;
            check_eq("stall_rmw", {31'd0, stall}, 32'd0);
            check_eq("memwr_rmw", {31'd0, mem_write}, 32'd1);
            check_eq("memaddr_rmw", {16'd0, mem_addr}, {16'd0, addr[17:2]});
            check_eq("wbvalid_rmw", {31'd0, wb_valid}, 32'd0);
        end
        if (we && !mis) ref_store(addr, size, wdata);
        @(negedge clk);
        check_eq("wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, !we && !mis && regw});
        check_eq("wb_data", wb_data, exp_data);
        check_eq("misalign_err", {31'd0, misalign_err}, {31'd0, mis});
        if (!we && !mis) check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
        if (we && !mis) check_eq("mem_word", dmem[addr[7:2]], ref_word(int'(addr[7:2])));
    endtask

    task automatic idle_cycle();
        logic [31:0] r;
        r = $urandom;
        req_valid = 1'b0; req_we = r[0]; req_size = r[2:1]; req_addr = r;
        @(negedge clk);
        check_eq("idle_wbvalid", {31'd0, wb_valid}, 32'd0);
        check_eq("idle_regwrite", {31'd0, wb_regwrite}, 32'd0);
    endtask

    initial begin
        logic [31:0] r, a;
        clk = 1'b0; rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; req_regwrite = 1'b0;
        for (int i = 0; i < 65536; i++) dmem[i] = 32'd0;
        for (int i = 0; i < 64; i++) begin
            r = $urandom;
            dmem[i] = r;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = 8'(r >> (8*k));
        end
        #12;
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_memwr", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // word store then load
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 5'd1, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 5'd3, 1'b1);
        check_eq("lw_const", wb_data, 32'hDEADBEEF);

        // byte RMW
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 5'd1, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, 5'd1, 1'b0);
        check_eq("sb_const", dmem[16], 32'h1122AA44);

        // extension
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h8000F0FF, 5'd1, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h42, 32'd0, 5'd4, 1'b1);
        check_eq("lh_const", wb_data, 32'hFFFF8000);
        issue(1'b0, 2'b01, 1'b1, 32'h42, 32'd0, 5'd5, 1'b1);
        check_eq("lhu_const", wb_data, 32'h00008000);
        issue(1'b0, 2'b00, 1'b0, 32'h40, 32'd0, 5'd6, 1'b1);
        check_eq("lb_const", wb_data, 32'hFFFFFFFF);
        issue(1'b0, 2'b00, 1'b1, 32'h41, 32'd0, 5'd7, 1'b1);
        check_eq("lbu_const", wb_data, 32'h000000F0);

        // reset in the middle of an RMW
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 5'd1, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h40; req_wdata = 32'h5555;
        #1;
        check_eq("sh_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        check_eq("sh_rmw_memwr", {31'd0, mem_write}, 32'd1);
        rst = 1'b1; #1;
        check_eq("rstmid_memwr", {31'd0, mem_write}, 32'd0);
        check_eq("rstmid_idle_stall", {31'd0, stall}, 32'd1);
        check_eq("rstmid_wbvalid", {31'd0, wb_valid}, 32'd0);
        req_valid = 1'b0; #1;
        check_eq("rstmid_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstmid_mem", dmem[16], 32'h11223344);
        check_eq("rstmid_wbvalid2", {31'd0, wb_valid}, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 5'd2, 1'b1);

        // misaligned word load
        issue(1'b0, 2'b10, 1'b0, 32'h42, 32'd0, 5'd8, 1'b1);
`ifdef MISALIGN_TRAP_EN
        check_eq("mis_err_const", {31'd0, misalign_err}, 32'd1);
        check_eq("mis_regw_const", {31'd0, wb_regwrite}, 32'd0);
`else
        check_eq("mis_word_const", wb_data, 32'h11223344);
        check_eq("mis_err_const", {31'd0, misalign_err}, 32'd0);
`endif

        // back-to-back: sb then lbu held during the stall
        issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h00000001, 5'd1, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h40, 32'd0, 5'd9, 1'b1);
        check_eq("b2b_lbu_const", wb_data, 32'h00000001);
        idle_cycle();

        // random traffic
        for (int t = 0; t < 400; t++) begin
            r = $urandom;
            if (r[2:0] == 3'd0) begin
                idle_cycle();
            end else begin
                a = $urandom;
                issue(r[3], r[5:4], r[6], {a[31:18], 10'd0, a[7:0]}, $urandom,
                      5'(r[12:8]), r[13]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
